// File: rtl/debouncer_bank.sv
// debouncer_bank: multi-channel input debouncer with edge pulses and a long-press flag.
//   clock   : system clock, all state updates on its rising edge
//   reset   : asynchronous, active-high reset
//   in      : raw asynchronous inputs, one bit per channel
//   out     : debounced levels (a new level is accepted only after it is stable for 2^COUNTER_WIDTH clocks)
//   rise    : one-clock pulse coincident with out[i] going 0->1
//   fall    : one-clock pulse coincident with out[i] going 1->0
//   held    : out[i] has been 1 long enough for its hold counter to saturate
//   changed : OR of rise|fall across all channels, coincident with them
module debouncer_bank #(
    parameter int unsigned         CHANNELS      = 4,
    parameter int unsigned         COUNTER_WIDTH = 16,
    parameter int unsigned         SYNC_STAGES   = 2,
    parameter int unsigned         HOLD_WIDTH    = 24,
    parameter logic [CHANNELS-1:0] RESET_VALUE   = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] held,
    output logic                changed
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [HOLD_WIDTH-1:0]    HOLD_MAX = '1;

    logic [CHANNELS-1:0]      sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0]      sync_last;

    logic [COUNTER_WIDTH-1:0] cnt_q  [CHANNELS];
    logic [COUNTER_WIDTH-1:0] cnt_d  [CHANNELS];
    logic [HOLD_WIDTH-1:0]    hold_q [CHANNELS];
    logic [HOLD_WIDTH-1:0]    hold_d [CHANNELS];

    logic [CHANNELS-1:0]      out_q,  out_d;
    logic [CHANNELS-1:0]      rise_q, rise_d;
    logic [CHANNELS-1:0]      fall_q, fall_d;
    logic [CHANNELS-1:0]      held_q, held_d;
    logic                     changed_q, changed_d;

    // Input synchroniser chains; only the last stage is consumed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Next-state logic for stability counters, levels, pulses and hold tracking.
    always_comb begin
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        out_d     = out_q;
        rise_d    = '0;
        fall_d    = '0;
        held_d    = '0;
        changed_d = 1'b0;

        for (int unsigned i = 0; i < CHANNELS; i++) begin
            // Any return to the current level restarts the stability window.
            if (sync_last[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                out_d[i] = sync_last[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + COUNTER_WIDTH'(1);
            end

            rise_d[i] = out_d[i] & ~out_q[i];
            fall_d[i] = ~out_d[i] & out_q[i];

            // Clearing on the next level lets held drop on the same edge as fall.
            if (!out_d[i]) begin
                hold_d[i] = '0;
            end else if (out_q[i] && (hold_q[i] != HOLD_MAX)) begin
                hold_d[i] = hold_q[i] + HOLD_WIDTH'(1);
            end

            held_d[i] = out_d[i] & (hold_d[i] == HOLD_MAX);
        end

        changed_d = |(rise_d | fall_d);
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i]  <= '0;
                hold_q[i] <= '0;
            end
            out_q     <= RESET_VALUE;
            rise_q    <= '0;
            fall_q    <= '0;
            held_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            out_q     <= out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            held_q    <= held_d;
            changed_q <= changed_d;
        end
    end

    assign out     = out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign held    = held_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_debouncer_bank.sv
// Directed bench for debouncer_bank: two instances (idle level 00 and 11), CHANNELS=2,
// COUNTER_WIDTH=2, SYNC_STAGES=2, HOLD_WIDTH=3. A stable step sampled first on edge 1
// reaches out on edge 6; held sets 7 edges after out rises.
module tb_debouncer_bank;

    logic       clock;
    logic       reset;
    logic [1:0] in_a, in_b;
    logic [1:0] out_a, rise_a, fall_a, held_a;
    logic [1:0] out_b, rise_b, fall_b, held_b;
    logic       changed_a, changed_b;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;

    debouncer_bank #(
        .CHANNELS(2), .COUNTER_WIDTH(2), .SYNC_STAGES(2), .HOLD_WIDTH(3), .RESET_VALUE(2'b00)
    ) dut_a (
        .clock(clock), .reset(reset), .in(in_a), .out(out_a),
        .rise(rise_a), .fall(fall_a), .held(held_a), .changed(changed_a)
    );

    debouncer_bank #(
        .CHANNELS(2), .COUNTER_WIDTH(2), .SYNC_STAGES(2), .HOLD_WIDTH(3), .RESET_VALUE(2'b11)
    ) dut_b (
        .clock(clock), .reset(reset), .in(in_b), .out(out_b),
        .rise(rise_b), .fall(fall_b), .held(held_b), .changed(changed_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (edge %0d): observed %b expected %b", tag, edge_no, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        edge_no++;
    endtask

    initial begin
        reset = 1'b1;
        in_a  = 2'b00;
        in_b  = 2'b11;
        #3;
        check("rst_a_out", out_a, 2'b00);
        check("rst_a_rise", rise_a, 2'b00);
        check("rst_a_fall", fall_a, 2'b00);
        check("rst_a_held", held_a, 2'b00);
        check("rst_a_changed", {1'b0, changed_a}, 2'b00);
        check("rst_b_out", out_b, 2'b11);
        check("rst_b_held", held_b, 2'b00);
        tick();
        tick();

        // Release reset; ch0 of A steps to 1 while B idles high and counts hold.
        reset = 1'b0;
        in_a  = 2'b01;
        edge_no = 0;
        for (int e = 1; e <= 14; e++) begin
            tick();
            check("t1_out", out_a, (e >= 6) ? 2'b01 : 2'b00);
            check("t1_rise", rise_a, (e == 6) ? 2'b01 : 2'b00);
            check("t1_fall", fall_a, 2'b00);
            check("t1_changed", {1'b0, changed_a}, (e == 6) ? 2'b01 : 2'b00);
            check("t4_held", held_a, (e >= 13) ? 2'b01 : 2'b00);
            check("t6_out", out_b, 2'b11);
            check("t6_rise", rise_b, 2'b00);
            check("t6_held", held_b, (e >= 7) ? 2'b11 : 2'b00);
        end

        // Release ch0: held must drop on the same edge as fall.
        in_a = 2'b00;
        edge_no = 0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check("t4f_out", out_a, (e >= 6) ? 2'b00 : 2'b01);
            check("t4f_fall", fall_a, (e == 6) ? 2'b01 : 2'b00);
            check("t4f_held", held_a, (e >= 6) ? 2'b00 : 2'b01);
            check("t4f_changed", {1'b0, changed_a}, (e == 6) ? 2'b01 : 2'b00);
        end

        // Bring ch1 high so it can fall while ch0 rises.
        in_a = 2'b10;
        edge_no = 0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check("t3p_out", out_a, (e >= 6) ? 2'b10 : 2'b00);
            check("t3p_rise", rise_a, (e == 6) ? 2'b10 : 2'b00);
        end

        // Simultaneous opposite transitions on both channels.
        in_a = 2'b01;
        edge_no = 0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check("t3_out", out_a, (e >= 6) ? 2'b01 : 2'b10);
            check("t3_rise", rise_a, (e == 6) ? 2'b01 : 2'b00);
            check("t3_fall", fall_a, (e == 6) ? 2'b10 : 2'b00);
            check("t3_changed", {1'b0, changed_a}, (e == 6) ? 2'b01 : 2'b00);
        end

        // ch1 bounces 1,0,1,0 for two clocks each; level must not move.
        edge_no = 0;
        for (int p = 0; p < 4; p++) begin
            in_a = (p % 2 == 0) ? 2'b11 : 2'b01;
            repeat (2) begin
                tick();
                check("t2_bounce_out", out_a, 2'b01);
                check("t2_bounce_rise", rise_a, 2'b00);
            end
        end
        in_a = 2'b11;
        edge_no = 0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check("t2_out", out_a, (e >= 6) ? 2'b11 : 2'b01);
            check("t2_rise", rise_a, (e == 6) ? 2'b10 : 2'b00);
        end

        // ch0 back to 0, ch1 stays high (and is held by now).
        in_a = 2'b10;
        edge_no = 0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check("t5p_out", out_a, (e >= 6) ? 2'b10 : 2'b11);
            check("t5p_fall", fall_a, (e == 6) ? 2'b01 : 2'b00);
        end
        check("t5p_held_a", held_a, 2'b10);
        check("t5p_held_b", held_b, 2'b11);

        // ch0 counts to 2, then reset hits between edges.
        in_a = 2'b11;
        edge_no = 0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check("t5_count_out", out_a, 2'b10);
        end
        #1;
        reset = 1'b1;
        #1;
        check("t5_async_out", out_a, 2'b00);
        check("t5_async_held", held_a, 2'b00);
        check("t5_async_rise", rise_a, 2'b00);
        check("t5_async_fall", fall_a, 2'b00);
        check("t5_async_changed", {1'b0, changed_a}, 2'b00);
        check("t5_async_b_out", out_b, 2'b11);
        check("t5_async_b_held", held_b, 2'b00);
        tick();
        reset = 1'b0;

        // Full latency again after release; B restarts its hold count.
        edge_no = 0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check("t5_out", out_a, (e >= 6) ? 2'b11 : 2'b00);
            check("t5_rise", rise_a, (e == 6) ? 2'b11 : 2'b00);
            check("t5_changed", {1'b0, changed_a}, (e == 6) ? 2'b01 : 2'b00);
            check("t5_b_rise", rise_b, 2'b00);
            check("t5_b_held", held_b, (e >= 7) ? 2'b11 : 2'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
